// File: rtl/acc_seq_pkg.sv
// Shared opcodes, sequencer states and ACC source-select codes for acc_seq_ctrl.
package acc_seq_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        FETCH_IMM,
        EXEC,
        HALT
    } state_e;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    // Opcodes whose EXEC cycle writes the accumulator from the ALU or register file.
    function automatic logic loads_acc_from_dp(input logic [2:0] op);
        return (op == OP_LDR) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/acc_seq_pc.sv
// Program counter for acc_seq_ctrl: async reset to RESET_PC, +1 on inc_en, wraps mod 2^ADDR_W.
module acc_seq_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: fetch/decode/exec sequencer issuing one-cycle control words to the ACC datapath.
// Define ACC_SEQ_CTRL_STEP_EN to add a 'step' input that releases one instruction per pulse.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              CLR,
`ifdef ACC_SEQ_CTRL_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [7:0]        imm_out,
    output logic [1:0]        reg_addr,
    output logic [2:0]        alu_op,
    output logic              S1,
    output logic              S0,
    output logic              LoadACC,
    output logic              LoadReg,
    output logic              halted
);

    // Memory handshake: a read completes on any rising edge where mem_req and mem_ack
    // are both 1; mem_req and mem_addr hold until that edge, mem_ack alone is ignored.

    state_e      state_q, state_d;
    logic [4:0]  ir_q, ir_d;          // IR[7:3] only; IR[2:0] is reserved and never stored
    logic [7:0]  imm_q, imm_d;
    logic [1:0]  reg_addr_q, reg_addr_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [1:0]  sel_q, sel_d;
    logic        mem_req_q, mem_req_d;
    logic        load_acc_q, load_acc_d;
    logic        load_reg_q, load_reg_d;
    logic        halted_q, halted_d;
    logic        xfer;
    logic        pc_inc;
    logic        fetch_go;
    logic [2:0]  opcode;

    assign xfer   = mem_req_q & mem_ack;
    assign opcode = ir_q[4:2];

`ifdef ACC_SEQ_CTRL_STEP_EN
    logic pend_q, pend_d;

    // A step pulse arms exactly one opcode fetch; the opcode transfer consumes it.
    always_comb begin
        pend_d = pend_q;
        if ((state_q == FETCH) && xfer) begin
            pend_d = 1'b0;
        end
        if (step) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign fetch_go = pend_d;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        reg_addr_d = reg_addr_q;
        alu_op_d   = alu_op_q;
        sel_d      = sel_q;
        load_acc_d = 1'b0;
        load_reg_d = 1'b0;
        pc_inc     = 1'b0;

        case (state_q)
            FETCH: begin
                if (xfer) begin
                    ir_d    = mem_data[7:3];
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LDI:  state_d = FETCH_IMM;
                    OP_HLT:  state_d = HALT;
                    default: begin
                        reg_addr_d = ir_q[1:0];
                        alu_op_d   = opcode;
                        load_acc_d = loads_acc_from_dp(opcode);
                        load_reg_d = (opcode == OP_STA);
                        sel_d      = (opcode == OP_LDR) ? SEL_REG : SEL_ALU;
                        state_d    = EXEC;
                    end
                endcase
            end
            FETCH_IMM: begin
                if (xfer) begin
                    imm_d      = mem_data;
                    pc_inc     = 1'b1;
                    load_acc_d = 1'b1;
                    sel_d      = SEL_IMM;
                    state_d    = EXEC;
                end
            end
            EXEC:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        halted_d  = (state_d == HALT);
        mem_req_d = ((state_d == FETCH) && fetch_go) || (state_d == FETCH_IMM);
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            imm_q      <= '0;
            reg_addr_q <= '0;
            alu_op_q   <= '0;
            sel_q      <= SEL_ALU;
            mem_req_q  <= 1'b0;
            load_acc_q <= 1'b0;
            load_reg_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            reg_addr_q <= reg_addr_d;
            alu_op_q   <= alu_op_d;
            sel_q      <= sel_d;
            mem_req_q  <= mem_req_d;
            load_acc_q <= load_acc_d;
            load_reg_q <= load_reg_d;
            halted_q   <= halted_d;
        end
    end

    acc_seq_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (CLR),
        .inc_en (pc_inc),
        .pc     (mem_addr)
    );

    assign mem_req  = mem_req_q;
    assign imm_out  = imm_q;
    assign reg_addr = reg_addr_q;
    assign alu_op   = alu_op_q;
    assign S1       = sel_q[1];
    assign S0       = sel_q[0];
    assign LoadACC  = load_acc_q;
    assign LoadReg  = load_reg_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl: default instance (RESET_PC=00) plus a RESET_PC=FF wrap instance.
`timescale 1ns/1ps
module tb_acc_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr0, clr1;

    // ---------------- instance 0 (RESET_PC = 00) ----------------
    logic       mem_req0, mem_ack0, s1_0, s0_0, load_acc0, load_reg0, halted0;
    logic [7:0] mem_addr0, mem_data0, imm0;
    logic [1:0] reg_addr0;
    logic [2:0] alu_op0;
    logic [7:0] mem0 [256];
    assign mem_data0 = mem0[mem_addr0];

    // ---------------- instance 1 (RESET_PC = FF) ----------------
    logic       mem_req1, mem_ack1, s1_1, s0_1, load_acc1, load_reg1, halted1;
    logic [7:0] mem_addr1, mem_data1, imm1;
    logic [1:0] reg_addr1;
    logic [2:0] alu_op1;
    logic [7:0] mem1 [256];
    assign mem_data1 = mem1[mem_addr1];

`ifdef ACC_SEQ_CTRL_STEP_EN
    logic step0;
`endif

    acc_seq_ctrl dut0 (
        .clk(clk), .CLR(clr0),
`ifdef ACC_SEQ_CTRL_STEP_EN
        .step(step0),
`endif
        .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_ack(mem_ack0), .mem_data(mem_data0),
        .imm_out(imm0), .reg_addr(reg_addr0), .alu_op(alu_op0), .S1(s1_0), .S0(s0_0),
        .LoadACC(load_acc0), .LoadReg(load_reg0), .halted(halted0)
    );

    acc_seq_ctrl #(.RESET_PC(8'hFF)) dut1 (
        .clk(clk), .CLR(clr1),
`ifdef ACC_SEQ_CTRL_STEP_EN
        .step(1'b1),
`endif
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack1), .mem_data(mem_data1),
        .imm_out(imm1), .reg_addr(reg_addr1), .alu_op(alu_op1), .S1(s1_1), .S0(s0_1),
        .LoadACC(load_acc1), .LoadReg(load_reg1), .halted(halted1)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard: expected opcode/immediate fetch addresses on dut0 ----------------
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (!clr0 && mem_req0 && mem_ack0) begin
            if (exp_q.size() == 0) begin
                check("xfer_extra", 32'(exp_q.size()), 1);
            end else begin
                check("xfer_addr", 32'(mem_addr0), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill0(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 256; i++) mem0[i] = 8'hE0;
        mem0[0] = b0; mem0[1] = b1; mem0[2] = b2; mem0[3] = b3;
    endtask

    task automatic restart0;
        clr0 = 1'b1;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr0 = 1'b1; clr1 = 1'b1;
        mem_ack0 = 1'b1; mem_ack1 = 1'b1;
`ifdef ACC_SEQ_CTRL_STEP_EN
        step0 = 1'b1;
`endif
        fill0(8'h20, 8'h5A, 8'h68, 8'hE0);
        for (int i = 0; i < 256; i++) mem1[i] = 8'hE0;
        mem1[8'hFF] = 8'h20;
        mem1[8'h00] = 8'h33;
        tick(2);

        // reset values
        check("rst_mem_req",  32'(mem_req0),  0);
        check("rst_mem_addr", 32'(mem_addr0), 32'h00);
        check("rst_load_acc", 32'(load_acc0), 0);
        check("rst_load_reg", 32'(load_reg0), 0);
        check("rst_halted",   32'(halted0),   0);
        check("rst_sel",      32'({s1_0, s0_0}), 0);
        check("rst_addr_ff",  32'(mem_addr1), 32'hFF);

        // program 1: LDI 5A; STA r1; HLT  (zero wait)
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        clr0 = 1'b0;
        tick(1);
        check("p1_req",     32'(mem_req0),  1);
        check("p1_addr0",   32'(mem_addr0), 32'h00);
        tick(3);
        check("p1_ldi_acc", 32'(load_acc0), 1);
        check("p1_ldi_sel", 32'({s1_0, s0_0}), 32'h3);
        check("p1_ldi_imm", 32'(imm0),      32'h5A);
        check("p1_ldi_reg", 32'(load_reg0), 0);
        tick(1);
        check("p1_ldi_1cyc", 32'(load_acc0), 0);
        tick(2);
        check("p1_sta_reg",  32'(load_reg0), 1);
        check("p1_sta_addr", 32'(reg_addr0), 1);
        check("p1_sta_acc",  32'(load_acc0), 0);
        tick(1);
        check("p1_sta_1cyc", 32'(load_reg0), 0);
        tick(2);
        check("p1_halted",   32'(halted0),   1);
        check("p1_halt_req", 32'(mem_req0),  0);
        tick(5);
        check("p1_halt_stay", 32'(halted0),   1);
        check("p1_halt_pc",   32'(mem_addr0), 32'h04);
        check("p1_halt_strb", 32'({load_acc0, load_reg0, mem_req0}), 0);

        // program 2: LDR r2 with three memory wait states
        restart0();
        fill0(8'h50, 8'hE0, 8'hE0, 8'hE0);
        mem_ack0 = 1'b0;
        exp_q = '{8'h00, 8'h01};
        clr0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("p2_wait_req",  32'(mem_req0),  1);
            check("p2_wait_addr", 32'(mem_addr0), 32'h00);
        end
        mem_ack0 = 1'b1;
        tick(1);
        check("p2_decode_req", 32'(mem_req0),  0);
        check("p2_decode_acc", 32'(load_acc0), 0);
        tick(1);
        check("p2_ldr_acc",  32'(load_acc0), 1);
        check("p2_ldr_sel",  32'({s1_0, s0_0}), 32'h2);
        check("p2_ldr_reg",  32'(reg_addr0), 2);
        tick(1);
        check("p2_ldr_1cyc", 32'(load_acc0), 0);
        check("p2_next_addr", 32'(mem_addr0), 32'h01);
        tick(3);

        // program 3: LDI 11; ADD r3; HLT
        restart0();
        fill0(8'h20, 8'h11, 8'h98, 8'hE0);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        clr0 = 1'b0;
        tick(4);
        check("p3_ldi_sel", 32'({s1_0, s0_0}), 32'h3);
        tick(3);
        check("p3_add_acc", 32'(load_acc0), 1);
        check("p3_add_sel", 32'({s1_0, s0_0}), 32'h0);
        check("p3_add_op",  32'(alu_op0),   32'h4);
        check("p3_add_reg", 32'(reg_addr0), 3);
        check("p3_add_str", 32'(load_reg0), 0);
        tick(7);
        check("p3_halted",  32'(halted0),   1);

        // program 4: PC wrap inside LDI (opcode at FF, immediate at 00)
        clr1 = 1'b0;
        tick(1);
        check("p4_addr_ff",  32'(mem_addr1), 32'hFF);
        check("p4_req",      32'(mem_req1),  1);
        tick(2);
        check("p4_imm_req",  32'(mem_req1),  1);
        check("p4_imm_addr", 32'(mem_addr1), 32'h00);
        tick(1);
        check("p4_imm",      32'(imm1),      32'h33);
        check("p4_acc",      32'(load_acc1), 1);
        check("p4_sel",      32'({s1_1, s0_1}), 32'h3);
        check("p4_pc",       32'(mem_addr1), 32'h01);
        tick(4);
        check("p4_halted",   32'(halted1),   1);
        check("p4_no_str",   32'(load_reg1), 0);

        // program 5: CLR during a FETCH_IMM wait
        restart0();
        fill0(8'h20, 8'h77, 8'hE0, 8'hE0);
        exp_q = '{8'h00};
        clr0 = 1'b0;
        tick(2);
        mem_ack0 = 1'b0;
        tick(1);
        check("p5_imm_req",  32'(mem_req0),  1);
        check("p5_imm_addr", 32'(mem_addr0), 32'h01);
        tick(1);
        clr0 = 1'b1;
        #1;
        check("p5_clr_req",  32'(mem_req0),  0);
        check("p5_clr_addr", 32'(mem_addr0), 32'h00);
        check("p5_clr_imm",  32'(imm0),      0);
        check("p5_clr_reg",  32'(reg_addr0), 0);
        check("p5_clr_op",   32'(alu_op0),   0);
        check("p5_clr_strb", 32'({load_acc0, load_reg0, halted0}), 0);
        fill0(8'h00, 8'hE0, 8'hE0, 8'hE0);
        mem_ack0 = 1'b1;
        exp_q = '{8'h00, 8'h01};
        tick(1);
        clr0 = 1'b0;
        tick(1);
        check("p5_restart_addr", 32'(mem_addr0), 32'h00);
        for (int i = 0; i < 7; i++) begin
            check("p5_no_strobe", 32'({load_acc0, load_reg0}), 0);
            tick(1);
        end
        check("p5_halted", 32'(halted0), 1);
        check("p5_pc",     32'(mem_addr0), 32'h02);

`ifdef ACC_SEQ_CTRL_STEP_EN
        // single-step: NOPs advance one instruction per step pulse
        restart0();
        fill0(8'h00, 8'h00, 8'h00, 8'hE0);
        step0 = 1'b0;
        exp_q = '{8'h00};
        clr0 = 1'b0;
        tick(3);
        check("st_idle_req", 32'(mem_req0), 0);
        step0 = 1'b1;
        tick(1);
        step0 = 1'b0;
        tick(8);
        check("st_one_xfer", 32'(exp_q.size()), 0);
        check("st_req_low",  32'(mem_req0),  0);
        check("st_addr1",    32'(mem_addr0), 32'h01);
        exp_q.push_back(8'h01);
        step0 = 1'b1;
        tick(1);
        step0 = 1'b0;
        tick(8);
        check("st_two_xfer", 32'(exp_q.size()), 0);
        check("st_req_low2", 32'(mem_req0),  0);
        check("st_addr2",    32'(mem_addr0), 32'h02);
`endif

        check("xfer_left", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
